// File: rtl/bp_pht_updater.sv
// Purpose : PHT index hashing for fetch, resolved-branch buffering, and 2-bit counter write-back.
// Latency : resolve accepted in cycle N -> write visible on w_obus during N+2; f_* outputs are combinational.
// Backpressure: r_ready = !fifo_full; the FIFO drains one entry per cycle, so it stalls only when full.
//
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   f_valid/f_pc/f_is_br  - fetch slot; f_pred_state is the PHT data read at f_raddr
//   f_raddr/f_pred_taken  - PHT read index (pc ^ spec_ghr) and predicted direction
//   f_ghr_snap            - spec_ghr before this cycle's update, carried to resolve
//   r_*                   - resolved conditional branch, valid/ready handshake
//   w_obus                - {we, waddr, wdata} PHT write bus (registered)
//   arch_ghr              - committed global history
module bp_pht_updater #(
  parameter int PHT_AW     = 10,
  parameter int GHR_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                f_valid,
  input  logic [31:0]         f_pc,
  input  logic                f_is_br,
  input  logic [1:0]          f_pred_state,
  output logic [PHT_AW-1:0]   f_raddr,
  output logic                f_pred_taken,
  output logic [GHR_W-1:0]    f_ghr_snap,
  input  logic                r_valid,
  output logic                r_ready,
  input  logic [PHT_AW-1:0]   r_idx,
  input  logic [1:0]          r_state,
  input  logic                r_taken,
  input  logic                r_mispredict,
  input  logic [GHR_W-1:0]    r_ghr_snap,
  output logic [PHT_AW+2:0]   w_obus,
  output logic [GHR_W-1:0]    arch_ghr
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [PHT_AW-1:0] idx;
    logic [1:0]        state;
    logic              taken;
  } entry_t;

  entry_t            fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW:0]       count;
  logic [GHR_W-1:0]  spec_ghr;

  logic              w_we;
  logic [PHT_AW-1:0] w_waddr;
  logic [1:0]        w_wdata;

  logic              push;
  logic              pop;
  entry_t            head;
  logic [1:0]        base;
  logic [1:0]        next_wdata;

  // Bits of the inputs that the hash and prediction do not consume.
  logic              unused_bits;
  assign unused_bits = ^{f_pc[31:PHT_AW+2], f_pc[1:0], f_pred_state[0], r_ghr_snap[GHR_W-1]};

  // Fetch side: purely combinational from inputs and current spec_ghr.
  assign f_raddr      = f_pc[PHT_AW+1:2] ^ PHT_AW'(spec_ghr);
  assign f_pred_taken = f_pred_state[1];
  assign f_ghr_snap   = spec_ghr;

  // No push-through when full: ready ignores a pop in the same cycle.
  assign r_ready = (count != (PW+1)'(FIFO_DEPTH));
  assign push    = r_valid && r_ready;
  assign pop     = (count != '0);
  assign head    = fifo_mem[rd_ptr];
  assign w_obus  = {w_we, w_waddr, w_wdata};

  always_comb begin
    // A write to the same index issued last cycle has not reached the
    // snapshot the resolve carried, so forward the freshly written value.
    base = (w_we && (w_waddr == head.idx)) ? w_wdata : head.state;
    next_wdata = base;
    if (head.taken) begin
      if (base != 2'd3) next_wdata = base + 2'd1;
    end else begin
      if (base != 2'd0) next_wdata = base - 2'd1;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{idx: r_idx, state: r_state, taken: r_taken};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      spec_ghr <= '0;
      arch_ghr <= '0;
      w_we     <= 1'b0;
      w_waddr  <= '0;
      w_wdata  <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PW'(1);
        arch_ghr <= {arch_ghr[GHR_W-2:0], r_taken};
      end

      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(1);
        w_we    <= 1'b1;
        w_waddr <= head.idx;
        w_wdata <= next_wdata;
      end else begin
        w_we    <= 1'b0;
      end

      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (!push && pop) count <= count - (PW+1)'(1);

      // Recovery outranks the fetch shift; a younger fetch on the wrong path is discarded.
      if (push && r_mispredict)  spec_ghr <= {r_ghr_snap[GHR_W-2:0], r_taken};
      else if (f_valid && f_is_br) spec_ghr <= {spec_ghr[GHR_W-2:0], f_pred_taken};
    end
  end

endmodule
